// File: rtl/mips_pkg.sv
// mips_pkg
// Shared MIPS decode constants for the ID->EX issue stage: opcode and funct
// encodings, the 3-bit ALU control codes, the operand-2 source selector and
// the 16-bit immediate extension helpers.
package mips_pkg;

  // Primary opcodes (instr[31:26])
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_XORI  = 6'b001110;
  localparam logic [5:0] OP_LB    = 6'b100000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SB    = 6'b101000;
  localparam logic [5:0] OP_SW    = 6'b101011;

  // R-type function codes (instr[5:0])
  localparam logic [5:0] F_SLL = 6'b000000;
  localparam logic [5:0] F_SRL = 6'b000010;
  localparam logic [5:0] F_ADD = 6'b100000;
  localparam logic [5:0] F_SUB = 6'b100010;
  localparam logic [5:0] F_AND = 6'b100100;
  localparam logic [5:0] F_OR  = 6'b100101;
  localparam logic [5:0] F_XOR = 6'b100110;
  localparam logic [5:0] F_SLT = 6'b101010;

  // ALU control codes understood by the 32-bit ALU
  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_AND = 3'b001;
  localparam logic [2:0] ALU_OR  = 3'b010;
  localparam logic [2:0] ALU_SLL = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b100;
  localparam logic [2:0] ALU_SRL = 3'b101;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_XOR = 3'b111;

  // Source of ALU operand 2
  typedef enum logic [1:0] {
    OP2_RT    = 2'd0,
    OP2_IMM   = 2'd1,
    OP2_SHAMT = 2'd2
  } op2_sel_e;

  function automatic logic [31:0] sign_ext16(input logic [15:0] v);
    return {{16{v[15]}}, v};
  endfunction

  function automatic logic [31:0] zero_ext16(input logic [15:0] v);
    return {16'h0000, v};
  endfunction

endpackage

// File: rtl/alu_ctrl_decode.sv
// alu_ctrl_decode
// Purely combinational MIPS decoder for the ALU issue stage.
// Ports:
//   instr      in   raw 32-bit instruction
//   alu_ctrl   out  3-bit ALU control code
//   r1_rt      out  1 = operand 1 comes from rt (shifts), 0 = rs
//   r2_sel     out  operand 2 source (rt / extended immediate / shamt)
//   sign_ext   out  1 = sign-extend the immediate, 0 = zero-extend
//   dest_rt    out  1 = destination is rt (I-type), 0 = rd (R-type)
//   reg_write, mem_read, mem_write, mem_byte, is_branch, branch_ne
//              out  side-band controls for EX/MEM/WB
//   illegal    out  opcode/funct not supported by this datapath
module alu_ctrl_decode
  import mips_pkg::*;
(
  input  logic [31:0] instr,
  output logic [2:0]  alu_ctrl,
  output logic        r1_rt,
  output logic [1:0]  r2_sel,
  output logic        sign_ext,
  output logic        dest_rt,
  output logic        reg_write,
  output logic        mem_read,
  output logic        mem_write,
  output logic        mem_byte,
  output logic        is_branch,
  output logic        branch_ne,
  output logic        illegal
);

  logic [5:0] opcode;
  logic [5:0] funct;
  logic [4:0] rd;
  logic       unused_fields;

  assign opcode        = instr[31:26];
  assign funct         = instr[5:0];
  assign rd            = instr[15:11];
  assign unused_fields = ^{instr[25:16], instr[10:6]};

  // Defaults describe a harmless bubble; each supported encoding only
  // overrides what differs. Anything unmatched raises illegal with all
  // enables still low.
  always_comb begin
    alu_ctrl  = ALU_ADD;
    r1_rt     = 1'b0;
    r2_sel    = OP2_RT;
    sign_ext  = 1'b1;
    dest_rt   = 1'b0;
    reg_write = 1'b0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    mem_byte  = 1'b0;
    is_branch = 1'b0;
    branch_ne = 1'b0;
    illegal   = 1'b0;

    case (opcode)
      OP_RTYPE: begin
        // Writes to r0 are suppressed so the all-zero NOP is side-effect free
        reg_write = (rd != 5'd0);
        case (funct)
          F_ADD: alu_ctrl = ALU_ADD;
          F_SUB: alu_ctrl = ALU_SUB;
          F_AND: alu_ctrl = ALU_AND;
          F_OR:  alu_ctrl = ALU_OR;
          F_XOR: alu_ctrl = ALU_XOR;
          F_SLT: alu_ctrl = ALU_SLT;
          F_SLL: begin
            alu_ctrl = ALU_SLL;
            r1_rt    = 1'b1;
            r2_sel   = OP2_SHAMT;
          end
          F_SRL: begin
            alu_ctrl = ALU_SRL;
            r1_rt    = 1'b1;
            r2_sel   = OP2_SHAMT;
          end
          default: begin
            reg_write = 1'b0;
            illegal   = 1'b1;
          end
        endcase
      end
      OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI, OP_XORI: begin
        r2_sel    = OP2_IMM;
        dest_rt   = 1'b1;
        reg_write = 1'b1;
        // Logical immediates are zero-extended, arithmetic ones sign-extended
        sign_ext  = (opcode == OP_ADDI) || (opcode == OP_SLTI);
        case (opcode)
          OP_SLTI: alu_ctrl = ALU_SLT;
          OP_ANDI: alu_ctrl = ALU_AND;
          OP_ORI:  alu_ctrl = ALU_OR;
          OP_XORI: alu_ctrl = ALU_XOR;
          default: alu_ctrl = ALU_ADD;
        endcase
      end
      OP_LW, OP_LB: begin
        r2_sel    = OP2_IMM;
        dest_rt   = 1'b1;
        reg_write = 1'b1;
        mem_read  = 1'b1;
        mem_byte  = (opcode == OP_LB);
      end
      OP_SW, OP_SB: begin
        r2_sel    = OP2_IMM;
        mem_write = 1'b1;
        mem_byte  = (opcode == OP_SB);
      end
      OP_BEQ, OP_BNE: begin
        alu_ctrl  = ALU_SUB;
        is_branch = 1'b1;
        branch_ne = (opcode == OP_BNE);
      end
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/id_ex_alu_issue.sv
// id_ex_alu_issue
// ID->EX pipeline register feeding the 32-bit ALU. Decodes the instruction,
// muxes/extends the operands and registers everything with a valid/ready
// handshake, stall hold and flush kill.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   id_valid / id_ready   upstream handshake (id_ready is combinational)
//   instr, rs_data, rt_data  instruction and register-file read values
//   flush                 kill the ID/EX contents at the next edge
//   ex_valid / ex_ready   downstream handshake (ex_ready=0 stalls)
//   alu_r1, alu_r2, alu_ctrl  ALU operands and control
//   dest_reg, reg_write, mem_read, mem_write, mem_byte, store_data,
//   is_branch, branch_ne  EX/MEM/WB side-band
//   illegal               one-cycle pulse when an unsupported op is captured
module id_ex_alu_issue
  import mips_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  id_valid,
  output logic                  id_ready,
  input  logic [31:0]           instr,
  input  logic [DATA_W-1:0]     rs_data,
  input  logic [DATA_W-1:0]     rt_data,
  input  logic                  flush,
  output logic                  ex_valid,
  input  logic                  ex_ready,
  output logic [DATA_W-1:0]     alu_r1,
  output logic [DATA_W-1:0]     alu_r2,
  output logic [2:0]            alu_ctrl,
  output logic [REG_ADDR_W-1:0] dest_reg,
  output logic                  reg_write,
  output logic                  mem_read,
  output logic                  mem_write,
  output logic                  mem_byte,
  output logic [DATA_W-1:0]     store_data,
  output logic                  is_branch,
  output logic                  branch_ne,
  output logic                  illegal
);

  logic [2:0]            dec_alu_ctrl;
  logic                  dec_r1_rt;
  logic [1:0]            dec_r2_sel;
  logic                  dec_sign_ext;
  logic                  dec_dest_rt;
  logic                  dec_reg_write;
  logic                  dec_mem_read;
  logic                  dec_mem_write;
  logic                  dec_mem_byte;
  logic                  dec_is_branch;
  logic                  dec_branch_ne;
  logic                  dec_illegal;

  logic [DATA_W-1:0]     imm_ext;
  logic [DATA_W-1:0]     op1;
  logic [DATA_W-1:0]     op2;
  logic [REG_ADDR_W-1:0] dest;
  logic                  capture;
  logic                  unused_fields;

  alu_ctrl_decode u_decode (
    .instr     (instr),
    .alu_ctrl  (dec_alu_ctrl),
    .r1_rt     (dec_r1_rt),
    .r2_sel    (dec_r2_sel),
    .sign_ext  (dec_sign_ext),
    .dest_rt   (dec_dest_rt),
    .reg_write (dec_reg_write),
    .mem_read  (dec_mem_read),
    .mem_write (dec_mem_write),
    .mem_byte  (dec_mem_byte),
    .is_branch (dec_is_branch),
    .branch_ne (dec_branch_ne),
    .illegal   (dec_illegal)
  );

  // Register indices for rs come from the register file already read
  assign unused_fields = ^instr[31:21];

  assign id_ready = !ex_valid || ex_ready;
  assign capture  = id_valid && id_ready;

  // Operand selection: shifts put rt in r1 and the shift amount in r2
  always_comb begin
    imm_ext = dec_sign_ext ? sign_ext16(instr[15:0]) : zero_ext16(instr[15:0]);
    op1     = dec_r1_rt ? rt_data : rs_data;
    case (dec_r2_sel)
      OP2_IMM:   op2 = imm_ext;
      OP2_SHAMT: op2 = {{(DATA_W-5){1'b0}}, instr[10:6]};
      default:   op2 = rt_data;
    endcase
    dest = dec_dest_rt ? instr[20:16] : instr[15:11];
  end

  // ID/EX register. Priority: reset, flush, capture, drain; a stall
  // (ex_valid with no ex_ready) falls through every branch and holds.
  // Flush and drain only clear the valid bit and enables, so the datapath
  // fields keep their last value while no instruction is present.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid   <= 1'b0;
      alu_r1     <= '0;
      alu_r2     <= '0;
      alu_ctrl   <= ALU_ADD;
      dest_reg   <= '0;
      reg_write  <= 1'b0;
      mem_read   <= 1'b0;
      mem_write  <= 1'b0;
      mem_byte   <= 1'b0;
      store_data <= '0;
      is_branch  <= 1'b0;
      branch_ne  <= 1'b0;
      illegal    <= 1'b0;
    end else if (flush) begin
      ex_valid  <= 1'b0;
      reg_write <= 1'b0;
      mem_read  <= 1'b0;
      mem_write <= 1'b0;
      is_branch <= 1'b0;
      illegal   <= 1'b0;
    end else if (capture) begin
      // An unsupported instruction enters as a bubble flagged by illegal
      ex_valid   <= !dec_illegal;
      alu_r1     <= op1;
      alu_r2     <= op2;
      alu_ctrl   <= dec_alu_ctrl;
      dest_reg   <= dest;
      reg_write  <= dec_reg_write;
      mem_read   <= dec_mem_read;
      mem_write  <= dec_mem_write;
      mem_byte   <= dec_mem_byte;
      store_data <= rt_data;
      is_branch  <= dec_is_branch;
      branch_ne  <= dec_branch_ne;
      illegal    <= dec_illegal;
    end else if (id_ready) begin
      ex_valid  <= 1'b0;
      reg_write <= 1'b0;
      mem_read  <= 1'b0;
      mem_write <= 1'b0;
      is_branch <= 1'b0;
      illegal   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_id_ex_alu_issue.sv
// tb_id_ex_alu_issue
// Directed-vector bench for id_ex_alu_issue: each instruction is driven for
// one edge and the registered outputs are compared against hand-computed
// values one time unit after that edge.
module tb_id_ex_alu_issue;

  logic        clk;
  logic        rst_n;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] instr;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic        flush;
  logic        ex_valid;
  logic        ex_ready;
  logic [31:0] alu_r1;
  logic [31:0] alu_r2;
  logic [2:0]  alu_ctrl;
  logic [4:0]  dest_reg;
  logic        reg_write;
  logic        mem_read;
  logic        mem_write;
  logic        mem_byte;
  logic [31:0] store_data;
  logic        is_branch;
  logic        branch_ne;
  logic        illegal;

  int checkCount;
  int passCount;

  id_ex_alu_issue #(.DATA_W(32), .REG_ADDR_W(5)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .id_valid   (id_valid),
    .id_ready   (id_ready),
    .instr      (instr),
    .rs_data    (rs_data),
    .rt_data    (rt_data),
    .flush      (flush),
    .ex_valid   (ex_valid),
    .ex_ready   (ex_ready),
    .alu_r1     (alu_r1),
    .alu_r2     (alu_r2),
    .alu_ctrl   (alu_ctrl),
    .dest_reg   (dest_reg),
    .reg_write  (reg_write),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .mem_byte   (mem_byte),
    .store_data (store_data),
    .is_branch  (is_branch),
    .branch_ne  (branch_ne),
    .illegal    (illegal)
  );

  // 10-unit clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard time limit so the bench always terminates
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [31:0] rType(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd, input logic [4:0] sh,
                                        input logic [5:0] fn);
    return {6'b000000, rs, rt, rd, sh, fn};
  endfunction

  function automatic logic [31:0] iType(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  // Single comparison point: counts every check and reports mismatches
  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checkCount++;
    if (got === exp) passCount++;
    else $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
  endtask

  // Present one instruction for a single edge, then drop id_valid
  task automatic applyStimulus(input logic [31:0] i, input logic [31:0] a, input logic [31:0] b);
    id_valid = 1'b1;
    instr    = i;
    rs_data  = a;
    rt_data  = b;
    @(posedge clk);
    #1;
    id_valid = 1'b0;
  endtask

  initial begin
    checkCount = 0;
    passCount  = 0;
    rst_n    = 1'b0;
    id_valid = 1'b0;
    instr    = 32'h0;
    rs_data  = 32'h0;
    rt_data  = 32'h0;
    flush    = 1'b0;
    ex_ready = 1'b1;

    repeat (2) @(posedge clk);
    #1;
    $display("[TB] reset values");
    checkOutput("rst ex_valid", {31'b0, ex_valid}, 32'd0);
    checkOutput("rst alu_ctrl", {29'b0, alu_ctrl}, 32'd0);
    checkOutput("rst reg_write", {31'b0, reg_write}, 32'd0);
    checkOutput("rst alu_r1", alu_r1, 32'd0);
    checkOutput("rst id_ready", {31'b0, id_ready}, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // ADD $3,$1,$2
    applyStimulus(rType(5'd1, 5'd2, 5'd3, 5'd0, 6'b100000), 32'd5, 32'd7);
    checkOutput("add ex_valid", {31'b0, ex_valid}, 32'd1);
    checkOutput("add r1", alu_r1, 32'd5);
    checkOutput("add r2", alu_r2, 32'd7);
    checkOutput("add ctrl", {29'b0, alu_ctrl}, 32'd0);
    checkOutput("add dest", {27'b0, dest_reg}, 32'd3);
    checkOutput("add reg_write", {31'b0, reg_write}, 32'd1);

    // ADDI $5,$1,0xFFFC (sign-extended)
    applyStimulus(iType(6'b001000, 5'd1, 5'd5, 16'hFFFC), 32'd9, 32'd0);
    checkOutput("addi r1", alu_r1, 32'd9);
    checkOutput("addi r2", alu_r2, 32'hFFFF_FFFC);
    checkOutput("addi dest", {27'b0, dest_reg}, 32'd5);

    // ANDI $5,$1,0xFFFC (zero-extended)
    applyStimulus(iType(6'b001100, 5'd1, 5'd5, 16'hFFFC), 32'd9, 32'd0);
    checkOutput("andi r2", alu_r2, 32'h0000_FFFC);
    checkOutput("andi ctrl", {29'b0, alu_ctrl}, 32'd1);

    // SLL $4,$2,3 with rt=1
    applyStimulus(rType(5'd0, 5'd2, 5'd4, 5'd3, 6'b000000), 32'hDEAD, 32'd1);
    checkOutput("sll r1", alu_r1, 32'd1);
    checkOutput("sll r2", alu_r2, 32'd3);
    checkOutput("sll ctrl", {29'b0, alu_ctrl}, 32'd3);
    checkOutput("sll dest", {27'b0, dest_reg}, 32'd4);

    // SRL $4,$2,7
    applyStimulus(rType(5'd0, 5'd2, 5'd4, 5'd7, 6'b000010), 32'hDEAD, 32'h80);
    checkOutput("srl ctrl", {29'b0, alu_ctrl}, 32'd5);
    checkOutput("srl r2", alu_r2, 32'd7);

    // Remaining R-type codes
    applyStimulus(rType(5'd1, 5'd2, 5'd8, 5'd0, 6'b100010), 32'd1, 32'd2);
    checkOutput("sub ctrl", {29'b0, alu_ctrl}, 32'd6);
    applyStimulus(rType(5'd1, 5'd2, 5'd8, 5'd0, 6'b101010), 32'd1, 32'd2);
    checkOutput("slt ctrl", {29'b0, alu_ctrl}, 32'd4);
    applyStimulus(rType(5'd1, 5'd2, 5'd8, 5'd0, 6'b100110), 32'd1, 32'd2);
    checkOutput("xor ctrl", {29'b0, alu_ctrl}, 32'd7);

    // SLTI sign-extends too
    applyStimulus(iType(6'b001010, 5'd1, 5'd9, 16'h8000), 32'd1, 32'd0);
    checkOutput("slti ctrl", {29'b0, alu_ctrl}, 32'd4);
    checkOutput("slti r2", alu_r2, 32'hFFFF_8000);

    // NOP is valid but writes nothing
    applyStimulus(32'h0000_0000, 32'd0, 32'd0);
    checkOutput("nop ex_valid", {31'b0, ex_valid}, 32'd1);
    checkOutput("nop reg_write", {31'b0, reg_write}, 32'd0);

    // Idle cycle drains the stage
    @(posedge clk);
    #1;
    checkOutput("idle ex_valid", {31'b0, ex_valid}, 32'd0);

    // Stall: hold ADD while OR waits upstream
    applyStimulus(rType(5'd1, 5'd2, 5'd3, 5'd0, 6'b100000), 32'h11, 32'h22);
    ex_ready = 1'b0;
    id_valid = 1'b1;
    instr    = rType(5'd1, 5'd2, 5'd7, 5'd0, 6'b100101);
    rs_data  = 32'hAA;
    rt_data  = 32'h55;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      checkOutput("stall id_ready", {31'b0, id_ready}, 32'd0);
      checkOutput("stall r1", alu_r1, 32'h11);
      checkOutput("stall ctrl", {29'b0, alu_ctrl}, 32'd0);
    end
    ex_ready = 1'b1;
    @(posedge clk);
    #1;
    id_valid = 1'b0;
    checkOutput("release r1", alu_r1, 32'hAA);
    checkOutput("release ctrl", {29'b0, alu_ctrl}, 32'd2);
    checkOutput("release dest", {27'b0, dest_reg}, 32'd7);

    // Flush wins over capture of a store
    flush = 1'b1;
    applyStimulus(iType(6'b101011, 5'd1, 5'd2, 16'h0010), 32'h100, 32'h1234);
    flush = 1'b0;
    checkOutput("flush ex_valid", {31'b0, ex_valid}, 32'd0);
    checkOutput("flush mem_write", {31'b0, mem_write}, 32'd0);
    checkOutput("flush reg_write", {31'b0, reg_write}, 32'd0);

    // Unsupported opcode becomes a bubble with a one-cycle illegal pulse
    applyStimulus(iType(6'b111111, 5'd1, 5'd2, 16'h0000), 32'd1, 32'd2);
    checkOutput("ill ex_valid", {31'b0, ex_valid}, 32'd0);
    checkOutput("ill pulse", {31'b0, illegal}, 32'd1);
    @(posedge clk);
    #1;
    checkOutput("ill cleared", {31'b0, illegal}, 32'd0);

    // Unsupported funct
    applyStimulus(rType(5'd1, 5'd2, 5'd3, 5'd0, 6'b111111), 32'd1, 32'd2);
    checkOutput("ill funct", {31'b0, illegal}, 32'd1);
    checkOutput("ill funct rw", {31'b0, reg_write}, 32'd0);

    // LB $6,0x8004($1)
    applyStimulus(iType(6'b100000, 5'd1, 5'd6, 16'h8004), 32'h100, 32'd0);
    checkOutput("lb mem_read", {31'b0, mem_read}, 32'd1);
    checkOutput("lb mem_byte", {31'b0, mem_byte}, 32'd1);
    checkOutput("lb r2", alu_r2, 32'hFFFF_8004);
    checkOutput("lb dest", {27'b0, dest_reg}, 32'd6);
    checkOutput("lb illegal", {31'b0, illegal}, 32'd0);

    // SW $2,16($1)
    applyStimulus(iType(6'b101011, 5'd1, 5'd2, 16'h0010), 32'h100, 32'h1234);
    checkOutput("sw mem_write", {31'b0, mem_write}, 32'd1);
    checkOutput("sw store_data", store_data, 32'h1234);
    checkOutput("sw reg_write", {31'b0, reg_write}, 32'd0);
    checkOutput("sw mem_byte", {31'b0, mem_byte}, 32'd0);

    // BNE $1,$2
    applyStimulus(iType(6'b000101, 5'd1, 5'd2, 16'h0004), 32'd3, 32'd4);
    checkOutput("bne ctrl", {29'b0, alu_ctrl}, 32'd6);
    checkOutput("bne branch_ne", {31'b0, branch_ne}, 32'd1);
    checkOutput("bne is_branch", {31'b0, is_branch}, 32'd1);
    checkOutput("bne r2", alu_r2, 32'd4);
    checkOutput("bne reg_write", {31'b0, reg_write}, 32'd0);

    // Reset asserted in the middle of a stall takes effect immediately
    ex_ready = 1'b0;
    applyStimulus(rType(5'd1, 5'd2, 5'd3, 5'd0, 6'b100000), 32'h77, 32'h1);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("async rst ex_valid", {31'b0, ex_valid}, 32'd0);
    checkOutput("async rst r1", alu_r1, 32'd0);
    checkOutput("async rst reg_write", {31'b0, reg_write}, 32'd0);
    ex_ready = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
